// File: rtl/debounce_pkg.sv
// Shared types and defaults for the per-bit debouncer.
package debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  localparam int DB_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/debounce_cell.sv
// One-bit debouncer: stability counter, accepted level and rise/fall strobes.
//   state    | meaning
//   STABLE   | input agrees with level (or just accepted), cnt == 0
//   COUNTING | input differs, cnt holds consecutive differing samples
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int   CNT_WIDTH     = DB_CNT_WIDTH_DEFAULT,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_sync,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  db_state_t             state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  differ;
  logic                  accept;

  assign differ    = sample_en && (in_sync != level);
  assign accept    = differ && (cnt == LAST);
  assign rise_next = accept && !level;
  assign fall_next = accept && level;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE;
      cnt   <= '0;
      level <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // strobes clear on the next edge even while sampling is paused
      rise <= rise_next;
      fall <= fall_next;
      if (sample_en) begin
        if (!differ || accept) begin
          state <= STABLE;
          cnt   <= '0;
          if (accept) level <= ~level;
        end else if (state == STABLE) begin
          state <= COUNTING;
          cnt   <= CNT_WIDTH'(1);
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Vector debouncer with per-bit edge strobes and an any-change flag.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               CNT_WIDTH     = DB_CNT_WIDTH_DEFAULT,
  parameter int               STABLE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_sync,
  input  logic             sample_en,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_any
);

  if (STABLE_CYCLES < 1 || (STABLE_CYCLES >> CNT_WIDTH) != 0) begin : g_bad_stable_cycles
    $error("debounce_edge: STABLE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
  end

  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .CNT_WIDTH    (CNT_WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_BIT    (RESET_LEVEL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .in_sync  (in_sync[i]),
      .sample_en(sample_en),
      .level    (out_level[i]),
      .rise     (rise_pulse[i]),
      .fall     (fall_pulse[i]),
      .rise_next(rise_next[i]),
      .fall_next(fall_next[i])
    );
  end

  // built from next-state so it lines up with the strobes it summarises
  always_ff @(posedge clk) begin
    if (reset) change_any <= 1'b0;
    else       change_any <= |(rise_next | fall_next);
  end

endmodule
